// File: rtl/tm_tb_fill_seq.sv
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tm_tb_fill_seq
//
// Token-bucket fill sequencer for the second-level traffic-manager scheduler.
// On every sweep tick it walks queue IDs 0..NUM_QUEUES-1. For each queue it
// reads the CIR profile, the EIR profile and the fill destination port from the
// scheduler memory bank. It then offers one fill request per queue to the
// token-bucket fill logic over a valid/ready handshake.
//
// Ports:
//   clk, RESET_SIG (async, active low)   clock and reset
//   enable, fill_period                  sweep enable and tick period (0 = no ticks)
//   *_rd / *_raddr                       single-cycle read strobes and read address
//   *_ack / *_rdata                      read-done pulses, with data valid alongside
//   fill_req / fill_ready                fill request handshake
//   fill_qid, fill_cir, fill_eir,        queue being filled and its captured
//   fill_port                            profiles and destination port
//   sweep_busy                           high from sweep start to final acceptance
//   overrun_cnt                          saturating count of ticks dropped while busy
//------------------------------------------------------------------------------

`ifndef SECOND_LVL_QUEUE_ID_NBITS
`define SECOND_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef SHAPING_PROFILE_NBITS
`define SHAPING_PROFILE_NBITS 32
`endif
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 6
`endif
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif

module tm_tb_fill_seq #(
    parameter int QUEUE_NBITS  = `SECOND_LVL_QUEUE_ID_NBITS,
    parameter int NUM_QUEUES   = 1 << QUEUE_NBITS,
    parameter int PERIOD_NBITS = 16
) (
    input  logic                              clk,
    input  logic                              `RESET_SIG,
    input  logic                              enable,
    input  logic [PERIOD_NBITS-1:0]           fill_period,
    output logic                              shaping_profile_cir_rd,
    output logic                              shaping_profile_eir_rd,
    output logic                              fill_tb_dst_rd,
    output logic [QUEUE_NBITS-1:0]            shaping_profile_cir_raddr,
    output logic [QUEUE_NBITS-1:0]            shaping_profile_eir_raddr,
    output logic [QUEUE_NBITS-1:0]            fill_tb_dst_raddr,
    input  logic                              shaping_profile_cir_ack,
    input  logic                              shaping_profile_eir_ack,
    input  logic                              fill_tb_dst_ack,
    input  logic [`SHAPING_PROFILE_NBITS-1:0] shaping_profile_cir_rdata,
    input  logic [`SHAPING_PROFILE_NBITS-1:0] shaping_profile_eir_rdata,
    input  logic [`PORT_ID_NBITS-1:0]         fill_tb_dst_rdata,
    output logic                              fill_req,
    input  logic                              fill_ready,
    output logic [QUEUE_NBITS-1:0]            fill_qid,
    output logic [`SHAPING_PROFILE_NBITS-1:0] fill_cir,
    output logic [`SHAPING_PROFILE_NBITS-1:0] fill_eir,
    output logic [`PORT_ID_NBITS-1:0]         fill_port,
    output logic                              sweep_busy,
    output logic [7:0]                        overrun_cnt
);

    localparam int SP_NBITS   = `SHAPING_PROFILE_NBITS;
    localparam int PORT_NBITS = `PORT_ID_NBITS;
    localparam logic [QUEUE_NBITS-1:0] LAST_QID = QUEUE_NBITS'(NUM_QUEUES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT
    } fillState_t;

    fillState_t               state_q;
    logic [PERIOD_NBITS-1:0]  timer_q;
    logic [PERIOD_NBITS-1:0]  timer_d;
    logic [PERIOD_NBITS-1:0]  reloadVal;
    logic                     timerRun;
    logic                     tick;
    logic [7:0]               overrun_q;
    logic [7:0]               overrun_d;
    logic [QUEUE_NBITS-1:0]   qid_q;
    logic                     rd_q;
    logic                     busy_q;
    logic                     req_q;
    logic [2:0]               ackSeen_q;
    logic [2:0]               ackSeen_d;
    logic [SP_NBITS-1:0]      cir_q;
    logic [SP_NBITS-1:0]      eir_q;
    logic [PORT_NBITS-1:0]    port_q;

    // The tick timer counts down from fill_period-1 and fires when it reaches
    // zero. Whenever it is not allowed to run it sits at the reload value, so a
    // restart always sees a full period. A new fill_period is only picked up
    // when the counter reloads, never in the middle of a countdown.
    always_comb begin
        reloadVal = fill_period - PERIOD_NBITS'(1);
        timerRun  = enable && (fill_period != '0);
        tick      = timerRun && (timer_q == '0);
        timer_d   = timer_q - PERIOD_NBITS'(1);
        if (!timerRun || tick) begin
            timer_d = reloadVal;
        end
    end

    // Coming out of reset the timer holds a full period, so the first tick
    // lands fill_period clocks after release.
    always_ff @(posedge clk or negedge `RESET_SIG) begin
        if (!`RESET_SIG) begin
            timer_q <= reloadVal;
        end else begin
            timer_q <= timer_d;
        end
    end

    // A tick that lands while a sweep is still running (including the final
    // acceptance cycle) is dropped and counted. The count sticks at 255
    // rather than wrapping.
    always_comb begin
        overrun_d = overrun_q;
        if (tick && busy_q && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge `RESET_SIG) begin
        if (!`RESET_SIG) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    // Ack-seen flags for this cycle, with an ack that arrives now folded in.
    // The flags go all-ones in the same cycle as the last outstanding ack.
    always_comb begin
        ackSeen_d = ackSeen_q | {fill_tb_dst_ack, shaping_profile_eir_ack, shaping_profile_cir_ack};
    end

    // Main sweep sequencer. The strobe is raised on the edge that enters
    // ISSUE and is cleared by the default on the following edge. This makes
    // it a registered single-cycle pulse. Acks are only looked at in WAIT,
    // so stray acks elsewhere cannot disturb the captured data. A disable
    // only takes effect at the acceptance decision, so the queue in flight
    // always finishes its handshake first.
    always_ff @(posedge clk or negedge `RESET_SIG) begin
        if (!`RESET_SIG) begin
            state_q   <= IDLE;
            qid_q     <= '0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            req_q     <= 1'b0;
            ackSeen_q <= '0;
            cir_q     <= '0;
            eir_q     <= '0;
            port_q    <= '0;
        end else begin
            rd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q <= ISSUE;
                        qid_q   <= '0;
                        busy_q  <= 1'b1;
                        rd_q    <= 1'b1;
                    end
                end
                ISSUE: begin
                    ackSeen_q <= '0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (shaping_profile_cir_ack) begin
                        cir_q <= shaping_profile_cir_rdata;
                    end
                    if (shaping_profile_eir_ack) begin
                        eir_q <= shaping_profile_eir_rdata;
                    end
                    if (fill_tb_dst_ack) begin
                        port_q <= fill_tb_dst_rdata;
                    end
                    ackSeen_q <= ackSeen_d;
                    if (&ackSeen_d) begin
                        state_q <= PRESENT;
                        req_q   <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (fill_ready) begin
                        req_q <= 1'b0;
                        if ((qid_q == LAST_QID) || !enable) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            qid_q   <= qid_q + QUEUE_NBITS'(1);
                            state_q <= ISSUE;
                            rd_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign shaping_profile_cir_rd    = rd_q;
    assign shaping_profile_eir_rd    = rd_q;
    assign fill_tb_dst_rd            = rd_q;
    assign shaping_profile_cir_raddr = qid_q;
    assign shaping_profile_eir_raddr = qid_q;
    assign fill_tb_dst_raddr         = qid_q;
    assign fill_req                  = req_q;
    assign fill_qid                  = qid_q;
    assign fill_cir                  = cir_q;
    assign fill_eir                  = eir_q;
    assign fill_port                 = port_q;
    assign sweep_busy                = busy_q;
    assign overrun_cnt               = overrun_q;

endmodule

// File: tb/tb_tm_tb_fill_seq.sv
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_tm_tb_fill_seq
//
// Testbench for tm_tb_fill_seq with four queues. A memory responder answers
// each read with a programmable or random ack latency. Each time a read is
// issued, it also pushes the fill that the sweep rules predict. A monitor pops
// that prediction when fill_req rises and compares against it. Directed phases
// cover basic sweeps, skewed acks, backpressure, overrun saturation, enable
// drop and reset mid-request. A random phase follows them.
//------------------------------------------------------------------------------

`ifndef SECOND_LVL_QUEUE_ID_NBITS
`define SECOND_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef SHAPING_PROFILE_NBITS
`define SHAPING_PROFILE_NBITS 32
`endif
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 6
`endif
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif

module tb_tm_tb_fill_seq;

    localparam int QN  = 2;
    localparam int NQ  = 4;
    localparam int PN  = 16;
    localparam int SPW = `SHAPING_PROFILE_NBITS;
    localparam int PW  = `PORT_ID_NBITS;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [PN-1:0]   fillPeriod = '0;
    logic            cirRd, eirRd, dstRd;
    logic [QN-1:0]   cirAddr, eirAddr, dstAddr;
    logic            cirAck = 1'b0, eirAck = 1'b0, dstAck = 1'b0;
    logic [SPW-1:0]  cirData = '0, eirData = '0;
    logic [PW-1:0]   dstData = '0;
    logic            fillReq;
    logic            fillReady = 1'b0;
    logic [QN-1:0]   fillQid;
    logic [SPW-1:0]  fillCir, fillEir;
    logic [PW-1:0]   fillPort;
    logic            sweepBusy;
    logic [7:0]      overrunCnt;

    typedef struct {
        logic [QN-1:0]  qid;
        logic [SPW-1:0] cir;
        logic [SPW-1:0] eir;
        logic [PW-1:0]  port;
    } fillExp_t;

    fillExp_t        expQ[$];
    logic [SPW-1:0]  cirMem[NQ];
    logic [SPW-1:0]  eirMem[NQ];
    logic [PW-1:0]   dstMem[NQ];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int modelQid = 0;
    int accepted = 0;
    int busyCycles = 0;
    int maxHold = 0;
    int bpHold = 0;
    int expRiseCyc = 0;
    int latCir = 1, latEir = 1, latDst = 1;
    int latRandom = 0;
    int readyMode = 0;

    tm_tb_fill_seq #(
        .QUEUE_NBITS (QN),
        .NUM_QUEUES  (NQ),
        .PERIOD_NBITS(PN)
    ) dut (
        .clk                      (clk),
        .`RESET_SIG               (rst_n),
        .enable                   (enable),
        .fill_period              (fillPeriod),
        .shaping_profile_cir_rd   (cirRd),
        .shaping_profile_eir_rd   (eirRd),
        .fill_tb_dst_rd           (dstRd),
        .shaping_profile_cir_raddr(cirAddr),
        .shaping_profile_eir_raddr(eirAddr),
        .fill_tb_dst_raddr        (dstAddr),
        .shaping_profile_cir_ack  (cirAck),
        .shaping_profile_eir_ack  (eirAck),
        .fill_tb_dst_ack          (dstAck),
        .shaping_profile_cir_rdata(cirData),
        .shaping_profile_eir_rdata(eirData),
        .fill_tb_dst_rdata        (dstData),
        .fill_req                 (fillReq),
        .fill_ready               (fillReady),
        .fill_qid                 (fillQid),
        .fill_cir                 (fillCir),
        .fill_eir                 (fillEir),
        .fill_port                (fillPort),
        .sweep_busy               (sweepBusy),
        .overrun_cnt              (overrunCnt)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Counts rising edges since the last reset release. At a falling edge it
    // equals the number of active edges the DUT has seen since coming out of
    // reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Safety net so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_fill_req", 64'(fillReq), 64'd0);
        checkOutput("rst_rd_strobes", 64'({cirRd, eirRd, dstRd}), 64'd0);
        checkOutput("rst_sweep_busy", 64'(sweepBusy), 64'd0);
        checkOutput("rst_overrun", 64'(overrunCnt), 64'd0);
        checkOutput("rst_fill_data", 64'(fillCir) | 64'(fillEir) | 64'(fillPort) | 64'(fillQid), 64'd0);
        checkOutput("rst_raddr", 64'({cirAddr, eirAddr, dstAddr}), 64'd0);
    endtask

    // Asserts reset right away, wherever the clock happens to be. It checks
    // that the outputs fall asynchronously. It then clears the model and loads
    // new memory contents before releasing reset just after a falling edge.
    task automatic applyReset(input int period);
        fillPeriod = PN'(period);
        #1 rst_n = 1'b0;
        #1;
        checkResetOutputs();
        expQ.delete();
        modelQid   = 0;
        accepted   = 0;
        busyCycles = 0;
        maxHold    = 0;
        bpHold     = 0;
        enable     = 1'b1;
        for (int i = 0; i < NQ; i++) begin
            cirMem[i] = $urandom;
            eirMem[i] = $urandom;
            dstMem[i] = PW'($urandom);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input int lc, input int le, input int ld, input int lrand,
                                 input int rmode, input int period);
        latCir    = lc;
        latEir    = le;
        latDst    = ld;
        latRandom = lrand;
        readyMode = rmode;
        applyReset(period);
    endtask

    task automatic waitStrobe(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (cirRd) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic waitCyc(input int target);
        for (int i = 0; i < 100000 && cyc < target; i++) begin
            @(negedge clk);
        end
    endtask

    // Expected overrun count after edge c, for a 5-cycle period with
    // 12-cycle sweeps. Ticks fall every 5 edges. Each sweep swallows the next
    // two ticks, so one tick in three starts a sweep.
    function automatic int ovModel(input int c);
        int n;
        int v;
        n = c / 5;
        v = n - (n + 2) / 3;
        return (v > 255) ? 255 : v;
    endfunction

    // Memory responder and scoreboard producer. When a read is issued, it
    // picks ack latencies, schedules the three acks and drives the memory
    // word for the address read. It pushes the fill the sweep rules predict
    // for this step. It also records when fill_req should rise, which is
    // the cycle after the last ack. rdata carries junk whenever ack is low.
    initial begin : responder
        int cntC, cntE, cntD, mx, sCyc;
        logic [QN-1:0] aC, aE, aD;
        logic sC, sE, sD, sReq, prevRd;
        fillExp_t e;
        cntC = 0; cntE = 0; cntD = 0; prevRd = 1'b0;
        forever begin
            @(negedge clk);
            sC = cirRd; sE = eirRd; sD = dstRd; sReq = fillReq; sCyc = cyc;
            aC = cirAddr; aE = eirAddr; aD = dstAddr;
            #1;
            cirAck = 1'b0; eirAck = 1'b0; dstAck = 1'b0;
            cirData = $urandom; eirData = $urandom; dstData = PW'($urandom);
            if (!rst_n) begin
                cntC = 0; cntE = 0; cntD = 0; prevRd = 1'b0;
                continue;
            end
            if (cntC > 0) begin
                cntC--;
                if (cntC == 0) begin cirAck = 1'b1; cirData = cirMem[aC]; end
            end
            if (cntE > 0) begin
                cntE--;
                if (cntE == 0) begin eirAck = 1'b1; eirData = eirMem[aE]; end
            end
            if (cntD > 0) begin
                cntD--;
                if (cntD == 0) begin dstAck = 1'b1; dstData = dstMem[aD]; end
            end
            if (sC || sE || sD) begin
                checkOutput("rd_strobes_together", 64'({sC, sE, sD}), 64'd7);
                checkOutput("rd_single_cycle", 64'(prevRd), 64'd0);
                checkOutput("rd_while_req", 64'(sReq), 64'd0);
                checkOutput("cir_raddr", 64'(aC), 64'(modelQid));
                checkOutput("eir_raddr", 64'(aE), 64'(modelQid));
                checkOutput("dst_raddr", 64'(aD), 64'(modelQid));
                if (latRandom != 0) begin
                    cntC = $urandom_range(1, 6);
                    cntE = $urandom_range(1, 6);
                    cntD = $urandom_range(1, 6);
                end else begin
                    cntC = latCir; cntE = latEir; cntD = latDst;
                end
                mx = cntC;
                if (cntE > mx) mx = cntE;
                if (cntD > mx) mx = cntD;
                expRiseCyc = sCyc + mx + 1;
                e.qid  = QN'(modelQid);
                e.cir  = cirMem[modelQid];
                e.eir  = eirMem[modelQid];
                e.port = dstMem[modelQid];
                expQ.push_back(e);
            end
            prevRd = sC || sE || sD;
        end
    end

    // fill_ready driver: 0 tied high, 1 holds qid 2 off for 20 cycles once,
    // 2 random, 3 never ready.
    initial begin : readyDriver
        logic sReq;
        logic [QN-1:0] sQid;
        forever begin
            @(negedge clk);
            sReq = fillReq;
            sQid = fillQid;
            #1;
            case (readyMode)
                0: fillReady = 1'b1;
                1: begin
                    if (sReq && (sQid == QN'(2)) && (bpHold < 20)) begin
                        bpHold++;
                        fillReady = 1'b0;
                    end else begin
                        fillReady = 1'b1;
                    end
                end
                2: fillReady = ($urandom_range(0, 3) != 0);
                default: fillReady = 1'b0;
            endcase
        end
    end

    // Scoreboard consumer. It samples after all drivers have settled for the
    // cycle. It pops a prediction whenever fill_req rises and checks the
    // request is held steady until accepted. On acceptance it advances the
    // model: the sweep ends after the last queue or when enable is low,
    // otherwise it moves to the next queue. It also tracks busy cycles and
    // checks that overrun_cnt only ever steps up by one.
    initial begin : monitor
        logic prevReq;
        logic [QN-1:0] hQid;
        logic [SPW-1:0] hCir, hEir;
        logic [PW-1:0] hPort;
        logic [7:0] prevOv;
        int hold;
        fillExp_t e;
        prevReq = 1'b0; prevOv = '0; hold = 0;
        hQid = '0; hCir = '0; hEir = '0; hPort = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prevReq = 1'b0;
                prevOv = '0;
                continue;
            end
            if (sweepBusy) busyCycles++;
            if (overrunCnt != prevOv) begin
                checkOutput("overrun_step", 64'(overrunCnt), 64'(prevOv) + 64'd1);
                prevOv = overrunCnt;
            end
            if (fillReq) begin
                if (!prevReq) begin
                    checkOutput("req_rise_cycle", 64'(cyc), 64'(expRiseCyc));
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_fill_req", 64'(fillQid), 64'hFFFF);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("fill_qid", 64'(fillQid), 64'(e.qid));
                        checkOutput("fill_cir", 64'(fillCir), 64'(e.cir));
                        checkOutput("fill_eir", 64'(fillEir), 64'(e.eir));
                        checkOutput("fill_port", 64'(fillPort), 64'(e.port));
                    end
                    hold = 0;
                end else begin
                    checkOutput("hold_qid", 64'(fillQid), 64'(hQid));
                    checkOutput("hold_cir", 64'(fillCir), 64'(hCir));
                    checkOutput("hold_eir", 64'(fillEir), 64'(hEir));
                    checkOutput("hold_port", 64'(fillPort), 64'(hPort));
                    hold++;
                    if (hold > maxHold) maxHold = hold;
                end
                hQid = fillQid; hCir = fillCir; hEir = fillEir; hPort = fillPort;
                if (fillReady) begin
                    accepted++;
                    if ((modelQid == NQ - 1) || !enable) modelQid = 0;
                    else modelQid++;
                end
            end
            prevReq = fillReq && !fillReady;
        end
    end

    initial begin : main
        int at, strobes;
        $display("[TB] starting tm_tb_fill_seq bench");

        // Basic sweeps: period 100, 1-cycle acks, ready tied high.
        applyStimulus(1, 1, 1, 0, 0, 100);
        waitStrobe(300, at);
        checkOutput("basic_first_tick", 64'(at), 64'd100);
        waitStrobe(300, at);
        waitStrobe(300, at);
        waitStrobe(300, at);
        waitStrobe(300, at);
        checkOutput("basic_second_sweep_tick", 64'(at), 64'd200);
        waitCyc(250);
        checkOutput("basic_busy_cycles", 64'(busyCycles), 64'd24);
        checkOutput("basic_accepted", 64'(accepted), 64'(2 * NQ));
        checkOutput("basic_overrun", 64'(overrunCnt), 64'd0);

        // Skewed acks: fill_req must follow the slowest (eir) ack.
        applyStimulus(1, 5, 3, 0, 0, 100);
        waitCyc(160);
        checkOutput("skew_accepted", 64'(accepted), 64'(NQ));
        checkOutput("skew_queue_empty", 64'(expQ.size()), 64'd0);

        // Backpressure on qid 2 for 20 cycles.
        applyStimulus(1, 1, 1, 0, 1, 100);
        waitCyc(170);
        checkOutput("bp_hold_cycles", 64'(maxHold), 64'd20);
        checkOutput("bp_accepted", 64'(accepted), 64'(NQ));

        // Overrun: period 5 is shorter than the 12-cycle sweep.
        applyStimulus(1, 1, 1, 0, 0, 5);
        waitCyc(100);
        checkOutput("ovr_at_100", 64'(overrunCnt), 64'(ovModel(100)));
        waitCyc(500);
        checkOutput("ovr_at_500", 64'(overrunCnt), 64'(ovModel(500)));
        waitCyc(1000);
        checkOutput("ovr_at_1000", 64'(overrunCnt), 64'(ovModel(1000)));
        waitCyc(2000);
        checkOutput("ovr_saturated", 64'(overrunCnt), 64'd255);

        // Enable drop while waiting on qid 1's reads.
        applyStimulus(3, 3, 3, 0, 0, 100);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cirRd && (cirAddr == QN'(1))) begin
                at = cyc;
                break;
            end
        end
        checkOutput("endrop_qid1_issued", 64'(at >= 0), 64'd1);
        @(negedge clk);
        #1 enable = 1'b0;
        strobes = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cirRd) strobes++;
        end
        checkOutput("endrop_no_more_reads", 64'(strobes), 64'd0);
        checkOutput("endrop_accepted", 64'(accepted), 64'd2);
        checkOutput("endrop_busy_clear", 64'(sweepBusy), 64'd0);
        #1 enable = 1'b1;
        waitStrobe(300, at);
        checkOutput("endrop_restart_qid0", 64'(cirAddr), 64'd0);
        repeat (100) @(negedge clk);
        checkOutput("endrop_accepted_after", 64'(accepted), 64'(2 + NQ));

        // Reset while a fill request is pending.
        applyStimulus(1, 1, 1, 0, 3, 50);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fillReq) begin
                at = cyc;
                break;
            end
        end
        checkOutput("rstp_req_seen", 64'(at >= 0), 64'd1);
        #2;
        applyStimulus(1, 1, 1, 0, 0, 50);
        waitStrobe(300, at);
        checkOutput("rstp_first_tick", 64'(at), 64'd50);
        repeat (40) @(negedge clk);
        checkOutput("rstp_accepted", 64'(accepted), 64'(NQ));

        // Random latencies, random ready and occasional enable toggles.
        applyStimulus(1, 1, 1, 1, 2, 60);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 59) == 0) enable = ~enable;
        end
        enable = 1'b0;
        readyMode = 0;
        for (int i = 0; i < 200 && sweepBusy; i++) begin
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checkOutput("rand_drained_busy", 64'(sweepBusy), 64'd0);
        checkOutput("rand_queue_empty", 64'(expQ.size()), 64'd0);
        checkOutput("rand_req_low", 64'(fillReq), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
